// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder: row-major rows in, column k delayed k beats out, with zero
// padding of the triangles and an (n-1)-beat zero flush after the last row of a matrix.
module systolic_skew_feeder #(
   parameter int BitSize     = 8,
   parameter int NumOfInputs = 2
) (
   input  logic                           clk,
   input  logic                           res_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_start,
   input  logic                           in_last,
   input  logic [NumOfInputs*BitSize-1:0] in_data,
   input  logic                           out_ready,
   output logic                           out_valid,
   output logic                           out_start,
   output logic                           out_last,
   output logic [NumOfInputs*BitSize-1:0] out_data
);

   localparam int DataW = NumOfInputs * BitSize;
   localparam int CntW  = (NumOfInputs > 1) ? $clog2(NumOfInputs) : 1;
   localparam bit SingleLane = (NumOfInputs == 1);
   localparam logic [CntW-1:0] LastCnt = CntW'((NumOfInputs > 1) ? (NumOfInputs - 2) : 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CntW-1:0]   flush_cnt_r;
   logic [CntW-1:0]   flush_cnt_nxt_s;
   logic              out_valid_r;
   logic              out_start_r;
   logic              out_last_r;
   logic              out_free_s;
   logic              in_ready_s;
   logic              accept_s;
   logic              adv_s;
   logic              last_flush_s;
   logic              last_beat_s;
   logic [DataW-1:0]  shift_in_s;

   // Handshake and lane-advance decode; in_ready is held low while reset is applied.
   always_comb begin
      out_free_s   = out_ready || !out_valid_r;
      in_ready_s   = res_n && out_free_s && (state_r != FLUSH);
      accept_s     = in_valid && in_ready_s;
      adv_s        = out_free_s && (accept_s || (state_r == FLUSH));
      last_flush_s = (state_r == FLUSH) && (flush_cnt_r == LastCnt);
      last_beat_s  = SingleLane ? (accept_s && in_last) : last_flush_s;
      shift_in_s   = (state_r == FLUSH) ? {DataW{1'b0}} : in_data;
   end

   // Matrix framing state and flush beat counter.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_r     <= IDLE;
         flush_cnt_r <= {CntW{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         flush_cnt_r <= flush_cnt_nxt_s;
      end
   end

   // Next-state logic: any accepted row streams; a last row enters the zero flush.
   always_comb begin
      state_nxt_s     = state_r;
      flush_cnt_nxt_s = flush_cnt_r;
      case (state_r)
         IDLE, STREAM: begin
            if (adv_s) begin
               flush_cnt_nxt_s = {CntW{1'b0}};
               if (in_last) begin
                  state_nxt_s = SingleLane ? IDLE : FLUSH;
               end else begin
                  state_nxt_s = STREAM;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         FLUSH: begin
            if (adv_s && last_flush_s) begin
               state_nxt_s     = IDLE;
               flush_cnt_nxt_s = {CntW{1'b0}};
            end else if (adv_s) begin
               flush_cnt_nxt_s = flush_cnt_r + CntW'(1);
            end else begin
               flush_cnt_nxt_s = flush_cnt_r;
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            flush_cnt_nxt_s = {CntW{1'b0}};
         end
      endcase
   end

   // Beat qualifiers: set on advance, cleared when the sink is free, frozen while stalled.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         out_valid_r <= 1'b0;
         out_start_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else if (adv_s) begin
         out_valid_r <= 1'b1;
         out_start_r <= accept_s && in_start;
         out_last_r  <= last_beat_s;
      end else if (out_free_s) begin
         out_valid_r <= 1'b0;
         out_start_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
         out_start_r <= out_start_r;
         out_last_r  <= out_last_r;
      end
   end

   // Lane k is a (k+1)-deep shift register; its last stage is column k of the output beat.
   for (genvar k = 0; k < NumOfInputs; k++) begin : g_lane
      logic [BitSize-1:0] stage_r [0:k];

      // Shift one stage per advance.
      always_ff @(posedge clk or negedge res_n) begin
         if (!res_n) begin
            for (int i = 0; i <= k; i++) begin
               stage_r[i] <= {BitSize{1'b0}};
            end
         end else if (adv_s) begin
            stage_r[0] <= shift_in_s[k*BitSize +: BitSize];
            for (int i = 1; i <= k; i++) begin
               stage_r[i] <= stage_r[i-1];
            end
         end
      end

      assign out_data[(NumOfInputs-1-k)*BitSize +: BitSize] = stage_r[k];
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_start = out_start_r;
   assign out_last  = out_last_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder (4 lanes): each matrix is expanded into its skewed beat list
// by index arithmetic, and every presented output beat is compared against that list.
module tb_systolic_skew_feeder;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int DW = N * W;

   logic          clk = 1'b0;
   logic          res_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_start;
   logic          in_last;
   logic [DW-1:0] in_data;
   logic          out_ready;
   logic          out_valid;
   logic          out_start;
   logic          out_last;
   logic [DW-1:0] out_data;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          s;
      logic          l;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks   = 0;
   int   n_pass     = 0;
   int   beats_seen = 0;
   bit   cmp_en     = 1'b0;
   int   rdy_mode   = 0;
   int   stall_at   = 0;
   int   stall_left = 0;
   bit   stall_done = 1'b0;

   always #5 clk = ~clk;

   systolic_skew_feeder #(.BitSize(W), .NumOfInputs(N)) dut (
      .clk      (clk),
      .res_n    (res_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_start (in_start),
      .in_last  (in_last),
      .in_data  (in_data),
      .out_ready(out_ready),
      .out_valid(out_valid),
      .out_start(out_start),
      .out_last (out_last),
      .out_data (out_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   // Beat j of an m-row matrix: column k carries row j-k when that row exists, else zero.
   function automatic logic [DW-1:0] beat_of(input logic [DW-1:0] rows[$], input int j);
      logic [DW-1:0] res;
      logic [DW-1:0] row;
      res = '0;
      for (int k = 0; k < N; k++) begin
         if ((j - k) >= 0 && (j - k) < rows.size()) begin
            row = rows[j-k];
            res[(N-1-k)*W +: W] = row[k*W +: W];
         end
      end
      return res;
   endfunction

   task automatic push_expected(input logic [DW-1:0] rows[$]);
      int m;
      exp_t e;
      m = rows.size();
      for (int j = 0; j < m + N - 1; j++) begin
         e.d = beat_of(rows, j);
         e.s = (j == 0);
         e.l = (j == m + N - 2);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_matrix(input logic [DW-1:0] rows[$], input int gap_pct,
                              input int gap_after, input int gap_len);
      int m;
      m = rows.size();
      push_expected(rows);
      for (int r = 0; r < m; r++) begin
         int t;
         bit acc;
         t   = 0;
         acc = 1'b0;
         in_valid = 1'b1;
         in_data  = rows[r];
         in_start = (r == 0);
         in_last  = (r == m - 1);
         while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
         end
         chk("row_accepted", acc, 1);
         in_valid = 1'b0;
         in_start = 1'b0;
         in_last  = 1'b0;
         if (r == gap_after) begin
            repeat (gap_len) begin @(posedge clk); #1; end
         end else if ($urandom_range(0, 99) < gap_pct) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
      end
   endtask

   task automatic drain(input string name, input int exp_beats, input int start_beats);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_beats"}, beats_seen - start_beats, exp_beats);
      repeat (2) begin @(posedge clk); #1; end
      chk({name, "_idle_valid"}, out_valid, 0);
   endtask

   // Sink behaviour: always ready, random back-pressure, or a scripted 3-cycle stall.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: out_ready = ($urandom_range(0, 99) < 70);
            2: begin
               if (stall_left > 0) begin
                  out_ready = 1'b0;
                  stall_left--;
               end else if (!stall_done && beats_seen == stall_at && out_valid) begin
                  out_ready  = 1'b0;
                  stall_left = 2;
                  stall_done = 1'b1;
               end else begin
                  out_ready = 1'b1;
               end
            end
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Output checker: every presented beat must equal the head of the expected list.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (cmp_en && res_n && out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_beat", out_valid, 0);
            end else begin
               e = exp_q[0];
               chk("beat_data", out_data, e.d);
               chk("beat_start", out_start, e.s);
               chk("beat_last", out_last, e.l);
               if (!out_ready) begin
                  chk("stall_in_ready", in_ready, 0);
               end else begin
                  void'(exp_q.pop_front());
                  beats_seen++;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] t1[$];
      logic [DW-1:0] t2[$];
      logic [DW-1:0] one[$];
      logic [DW-1:0] rnd[$];
      logic [DW-1:0] row;
      int b0;

      res_n     = 1'b0;
      in_valid  = 1'b0;
      in_start  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_start", out_start, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 0);

      for (int r = 0; r < N; r++) begin
         for (int k = 0; k < N; k++) row[k*W +: W] = W'(r * 16 + k);
         t1.push_back(row);
         t2.push_back(row ^ {N{8'h80}});
      end
      one.push_back(32'h08070605);

      chk("pin_t1_b0", beat_of(t1, 0), 32'h00000000);
      chk("pin_t1_b3", beat_of(t1, 3), 32'h30211203);
      chk("pin_t1_b4", beat_of(t1, 4), 32'h00312213);
      chk("pin_t1_b6", beat_of(t1, 6), 32'h00000033);
      chk("pin_one_b0", beat_of(one, 0), 32'h05000000);
      chk("pin_one_b3", beat_of(one, 3), 32'h00000008);

      res_n  = 1'b1;
      cmp_en = 1'b1;
      @(posedge clk);
      #1;

      b0 = beats_seen;
      send_matrix(t1, 0, -1, 0);
      drain("basic", 7, b0);

      b0 = beats_seen;
      stall_at   = b0 + 2;
      stall_done = 1'b0;
      stall_left = 0;
      rdy_mode   = 2;
      send_matrix(t1, 0, -1, 0);
      drain("stall", 7, b0);
      chk("stall_happened", stall_done, 1);
      rdy_mode = 0;

      b0 = beats_seen;
      send_matrix(t1, 0, 1, 2);
      drain("gap", 7, b0);

      b0 = beats_seen;
      send_matrix(t1, 0, -1, 0);
      send_matrix(t2, 0, -1, 0);
      drain("b2b", 14, b0);

      b0 = beats_seen;
      send_matrix(one, 0, -1, 0);
      drain("single", 4, b0);

      send_matrix(t1, 0, -1, 0);
      @(posedge clk);
      #1;
      cmp_en = 1'b0;
      exp_q.delete();
      res_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      res_n  = 1'b1;
      cmp_en = 1'b1;
      b0 = beats_seen;
      send_matrix(t1, 0, -1, 0);
      drain("after_rst", 7, b0);

      rdy_mode = 1;
      for (int mtx = 0; mtx < 20; mtx++) begin
         int m;
         m = $urandom_range(1, 6);
         rnd.delete();
         for (int r = 0; r < m; r++) rnd.push_back(DW'($urandom));
         b0 = beats_seen;
         send_matrix(rnd, 30, -1, 0);
         drain("random", m + N - 1, b0);
      end
      rdy_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
